// File: rtl/baud_pkg.sv
// Shared defaults, divisor type and effective-divisor helper for the baud tick generator.
// Optional fractional divisor support is enabled with the BAUD_FRAC_EN macro.
package baud_pkg;

  localparam int DEFAULT_DIV_WIDTH  = 16;
  localparam int DEFAULT_OVERSAMPLE = 16;
  localparam int DEFAULT_RESET_DIV  = 103;

  typedef logic [DEFAULT_DIV_WIDTH-1:0] div_t;

  // A divisor of zero behaves as one: a tick on every enabled cycle.
  function automatic logic [31:0] eff_div(input logic [31:0] div);
    if (div == 32'd0) begin
      return 32'd1;
    end else begin
      return div;
    end
  endfunction

endpackage

// File: rtl/baud_div_counter.sv
// Divide counter with shadow/active divisor producing the oversample tick.
// With BAUD_FRAC_EN defined, a 4-bit fractional accumulator stretches some periods by one cycle.
module baud_div_counter
  import baud_pkg::*;
#(
  parameter int DIV_WIDTH = DEFAULT_DIV_WIDTH,
  parameter int RESET_DIV = DEFAULT_RESET_DIV
) (
  input  logic                 CLKIN,
  input  logic                 RESETN,
  input  logic                 en,
  input  logic                 restart,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_in,
`ifdef BAUD_FRAC_EN
  input  logic [3:0]           frac_in,
`endif
  output logic                 reload_evt,
  output logic                 os_tick
);

  localparam logic [DIV_WIDTH-1:0] RESET_VAL = DIV_WIDTH'(RESET_DIV);
  localparam logic [DIV_WIDTH-1:0] RESET_CNT = DIV_WIDTH'(eff_div(32'(RESET_DIV)) - 32'd1);
  localparam logic [DIV_WIDTH-1:0] ONE       = DIV_WIDTH'(1);
  localparam logic [DIV_WIDTH-1:0] ZERO      = {DIV_WIDTH{1'b0}};

  logic [DIV_WIDTH-1:0] cnt_r, shd_r, act_r;
  logic                 os_tick_r;
  logic [DIV_WIDTH-1:0] shd_next_s, act_next_s, eff_s, cnt_next_s;
  logic                 reload_s, carry_s, take_s;

  // Divisor shadow/active selection and divide-counter next state.
  always_comb begin
    shd_next_s = div_load ? div_in : shd_r;
    reload_s   = en && !restart && (cnt_r == ZERO);
    take_s     = !en || restart || reload_s;
    if (take_s) begin
      act_next_s = shd_next_s;
    end else begin
      act_next_s = act_r;
    end
    eff_s = DIV_WIDTH'(eff_div(32'(act_next_s)));
    if (!en || restart) begin
      cnt_next_s = eff_s - ONE;
    end else if (reload_s) begin
      cnt_next_s = carry_s ? eff_s : eff_s - ONE;
    end else begin
      cnt_next_s = cnt_r - ONE;
    end
  end

`ifdef BAUD_FRAC_EN
  logic [3:0] fshd_r, fact_r, acc_r;
  logic [3:0] fshd_next_s, fact_next_s, acc_next_s;
  logic [4:0] fsum_s;

  // Fractional shadow/active and accumulator; a carry lengthens this reload by one cycle.
  always_comb begin
    fshd_next_s = div_load ? frac_in : fshd_r;
    fact_next_s = take_s ? fshd_next_s : fact_r;
    fsum_s      = {1'b0, acc_r} + {1'b0, fact_next_s};
    carry_s     = reload_s && fsum_s[4];
    if (!en || restart) begin
      acc_next_s = 4'd0;
    end else if (reload_s) begin
      acc_next_s = fsum_s[3:0];
    end else begin
      acc_next_s = acc_r;
    end
  end

  // Fractional state registers.
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      fshd_r <= 4'd0;
      fact_r <= 4'd0;
      acc_r  <= 4'd0;
    end else begin
      fshd_r <= fshd_next_s;
      fact_r <= fact_next_s;
      acc_r  <= acc_next_s;
    end
  end
`else
  assign carry_s = 1'b0;
`endif

  // Divisor and counter registers; os_tick is registered from the reload event.
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      cnt_r     <= RESET_CNT;
      shd_r     <= RESET_VAL;
      act_r     <= RESET_VAL;
      os_tick_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_next_s;
      shd_r     <= shd_next_s;
      act_r     <= act_next_s;
      os_tick_r <= reload_s;
    end
  end

  assign reload_evt = reload_s;
  assign os_tick    = os_tick_r;

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator: oversample tick plus bit tick every OVERSAMPLE oversample ticks.
// Defining BAUD_FRAC_EN adds the frac_in fractional divisor port.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int DIV_WIDTH  = DEFAULT_DIV_WIDTH,
  parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE,
  parameter int RESET_DIV  = DEFAULT_RESET_DIV
) (
  input  logic                 CLKIN,
  input  logic                 RESETN,
  input  logic                 en,
  input  logic                 div_load,
  input  logic [DIV_WIDTH-1:0] div_in,
  input  logic                 restart,
`ifdef BAUD_FRAC_EN
  input  logic [3:0]           frac_in,
`endif
  output logic                 os_tick,
  output logic                 bit_tick
);

  localparam int            OS_W    = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_MID  = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] OS_ZERO = {OS_W{1'b0}};

  logic            reload_evt_s;
  logic [OS_W-1:0] oscnt_r, oscnt_next_s;
  logic            bit_tick_r, bit_next_s;

  baud_div_counter #(
    .DIV_WIDTH (DIV_WIDTH),
    .RESET_DIV (RESET_DIV)
  ) u_div (
    .CLKIN      (CLKIN),
    .RESETN     (RESETN),
    .en         (en),
    .restart    (restart),
    .div_load   (div_load),
    .div_in     (div_in),
`ifdef BAUD_FRAC_EN
    .frac_in    (frac_in),
`endif
    .reload_evt (reload_evt_s),
    .os_tick    (os_tick)
  );

  // Oversample counter; restart parks it mid-bit so the next bit tick lands mid-bit.
  always_comb begin
    bit_next_s = reload_evt_s && (oscnt_r == OS_LAST);
    if (!en) begin
      oscnt_next_s = OS_ZERO;
    end else if (restart) begin
      oscnt_next_s = OS_MID;
    end else if (reload_evt_s) begin
      oscnt_next_s = (oscnt_r == OS_LAST) ? OS_ZERO : oscnt_r + OS_W'(1);
    end else begin
      oscnt_next_s = oscnt_r;
    end
  end

  // Oversample counter and bit tick registers.
  always_ff @(posedge CLKIN or negedge RESETN) begin
    if (!RESETN) begin
      oscnt_r    <= OS_ZERO;
      bit_tick_r <= 1'b0;
    end else begin
      oscnt_r    <= oscnt_next_s;
      bit_tick_r <= bit_next_s;
    end
  end

  assign bit_tick = bit_tick_r;

endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed, table-driven bench for baud_tick_gen with default parameters (OVERSAMPLE=16).
module tb_baud_tick_gen;

  logic        CLKIN;
  logic        RESETN;
  logic        en;
  logic        div_load;
  logic [15:0] div_in;
  logic        restart;
  logic        os_tick;
  logic        bit_tick;
`ifdef BAUD_FRAC_EN
  logic [3:0]  frac_in;
`endif

  int n_cmp;
  int n_bad;

  typedef struct {
    int div;
    int cycles;
    int exp_first_os;
    int exp_first_bit;
  } vec_t;

  vec_t vecs[6];

  baud_tick_gen dut (
    .CLKIN    (CLKIN),
    .RESETN   (RESETN),
    .en       (en),
    .div_load (div_load),
    .div_in   (div_in),
    .restart  (restart),
`ifdef BAUD_FRAC_EN
    .frac_in  (frac_in),
`endif
    .os_tick  (os_tick),
    .bit_tick (bit_tick)
  );

  initial begin
    CLKIN = 1'b0;
    forever #5 CLKIN = ~CLKIN;
  end

  task automatic step();
    @(posedge CLKIN);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Load a divisor with en low so it becomes active immediately.
  task automatic setup(input int div);
    en       = 1'b0;
    restart  = 1'b0;
    div_load = 1'b1;
    div_in   = 16'(div);
    step();
    div_load = 1'b0;
    step();
  endtask

  // Run n cycles, recording first os/bit tick index and any irregular spacing.
  task automatic run_obs(input int n, input int period, output int first_os,
                         output int first_bit, output int bad_gap, output int n_os);
    int last_os;
    int last_bit;
    first_os  = -1;
    first_bit = -1;
    bad_gap   = 0;
    n_os      = 0;
    last_os   = -1;
    last_bit  = -1;
    for (int k = 1; k <= n; k++) begin
      step();
      if (bit_tick && !os_tick) bad_gap++;
      if (os_tick) begin
        n_os++;
        if (last_os >= 0 && (k - last_os) != period) bad_gap++;
        if (first_os < 0) first_os = k;
        last_os = k;
      end
      if (bit_tick) begin
        if (last_bit >= 0 && (k - last_bit) != 16 * period) bad_gap++;
        if (first_bit < 0) first_bit = k;
        last_bit = k;
      end
    end
  endtask

  initial begin
    int fo, fb, bg, no;
    n_cmp    = 0;
    n_bad    = 0;
    RESETN   = 1'b0;
    en       = 1'b0;
    div_load = 1'b0;
    div_in   = 16'd0;
    restart  = 1'b0;
`ifdef BAUD_FRAC_EN
    frac_in  = 4'd0;
`endif

    vecs[0] = '{div: 103, cycles: 1700, exp_first_os: 103, exp_first_bit: 1648};
    vecs[1] = '{div: 0,   cycles: 40,   exp_first_os: 1,   exp_first_bit: 16};
    vecs[2] = '{div: 1,   cycles: 40,   exp_first_os: 1,   exp_first_bit: 16};
    vecs[3] = '{div: 7,   cycles: 240,  exp_first_os: 7,   exp_first_bit: 112};
    vecs[4] = '{div: 10,  cycles: 330,  exp_first_os: 10,  exp_first_bit: 160};
    vecs[5] = '{div: 4,   cycles: 140,  exp_first_os: 4,   exp_first_bit: 64};

    #23;
    check("reset_os_tick", int'(os_tick), 0);
    check("reset_bit_tick", int'(bit_tick), 0);
    RESETN = 1'b1;
    step();

    // Reset divisor used directly after reset.
    en = 1'b1;
    run_obs(1700, 103, fo, fb, bg, no);
    check("reset_div_first_os", fo, 103);
    check("reset_div_first_bit", fb, 1648);
    check("reset_div_spacing", bg, 0);

    // Table vectors.
    for (int i = 0; i < 6; i++) begin
      setup(vecs[i].div);
      en = 1'b1;
      run_obs(vecs[i].cycles, (vecs[i].div == 0) ? 1 : vecs[i].div, fo, fb, bg, no);
      check($sformatf("vec%0d_first_os", i), fo, vecs[i].exp_first_os);
      check($sformatf("vec%0d_first_bit", i), fb, vecs[i].exp_first_bit);
      check($sformatf("vec%0d_spacing", i), bg, 0);
    end

    // Divisor update mid-period: the running 103 period completes, then period 4.
    setup(103);
    en = 1'b1;
    run_obs(50, 103, fo, fb, bg, no);
    check("midload_early_ticks", no, 0);
    div_load = 1'b1;
    div_in   = 16'd4;
    step();
    div_load = 1'b0;
    run_obs(200, 4, fo, fb, bg, no);
    check("midload_first_os", fo, 52);
    check("midload_first_bit", fb, 112);
    check("midload_spacing", bg, 0);

    // Restart landing on an edge that would have registered a tick.
    setup(10);
    en = 1'b1;
    run_obs(29, 10, fo, fb, bg, no);
    check("restart_pre_ticks", no, 2);
    restart = 1'b1;
    step();
    restart = 1'b0;
    check("restart_edge_suppressed", int'(os_tick), 0);
    run_obs(170, 10, fo, fb, bg, no);
    check("restart_first_os", fo, 10);
    check("restart_first_bit", fb, 80);
    check("restart_spacing", bg, 0);

    // Restart together with div_load takes the new divisor.
    setup(10);
    en = 1'b1;
    run_obs(13, 10, fo, fb, bg, no);
    restart  = 1'b1;
    div_load = 1'b1;
    div_in   = 16'd5;
    step();
    restart  = 1'b0;
    div_load = 1'b0;
    run_obs(60, 5, fo, fb, bg, no);
    check("restart_load_first_os", fo, 5);
    check("restart_load_first_bit", fb, 40);

    // Restart with en low: disable wins, oversample counter returns to zero.
    setup(3);
    en = 1'b1;
    run_obs(5, 3, fo, fb, bg, no);
    restart = 1'b1;
    en      = 1'b0;
    step();
    restart = 1'b0;
    en      = 1'b1;
    run_obs(60, 3, fo, fb, bg, no);
    check("restart_en0_first_os", fo, 3);
    check("restart_en0_first_bit", fb, 48);

    // Enable dropped mid-period for 50 cycles, then resumed cleanly.
    setup(7);
    en = 1'b1;
    run_obs(10, 7, fo, fb, bg, no);
    check("en_pre_first_os", fo, 7);
    en = 1'b0;
    run_obs(50, 7, fo, fb, bg, no);
    check("en_low_os_count", no, 0);
    check("en_low_bit_tick", fb, -1);
    en = 1'b1;
    run_obs(120, 7, fo, fb, bg, no);
    check("en_resume_first_os", fo, 7);
    check("en_resume_first_bit", fb, 112);

    // Asynchronous reset while os_tick is high clears outputs before the next edge.
    setup(1);
    en = 1'b1;
    step();
    step();
    step();
    check("pre_areset_os_tick", int'(os_tick), 1);
    #3;
    RESETN = 1'b0;
    #1;
    check("areset_os_tick", int'(os_tick), 0);
    check("areset_bit_tick", int'(bit_tick), 0);
    #2;
    RESETN = 1'b1;
    run_obs(120, 103, fo, fb, bg, no);
    check("post_areset_first_os", fo, 103);
    check("post_areset_os_count", no, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
